// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the "&&payload&&" UART string deframer.
package uart_frame_pkg;

   localparam logic [7:0] AMP_CHAR = 8'h26;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   typedef enum logic [5:0] {
      S_IDLE    = 6'b000001,
      S_SYNC1   = 6'b000010,
      S_CONTENT = 6'b000100,
      S_AMP     = 6'b001000,
      S_WR2     = 6'b010000,
      S_DONE    = 6'b100000
   } state_t;

endpackage

// File: rtl/uart_frame_rx.sv
// Receive-side deframer: strips the "&&" header/trailer from the uart_rx byte
// stream and assembles the payload into a packed byte string.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int MAX_LEN     = 137,
   parameter int TIMEOUT_CLK = 43_400
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [7:0]             uart_rx_data,
   input  logic                   uart_rx_vld,
   output logic [8*MAX_LEN-1:0]   rx_string,
   output logic [7:0]             rx_length,
   output logic                   rx_busy,
   output logic                   rx_done,
   output logic                   rx_err,
   output logic [1:0]             rx_err_code
);

   localparam int              TW       = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CLK - 1);
   localparam logic [8:0]      CAP      = 9'(MAX_LEN);

   state_t        state;
   logic [7:0]    cnt;
   logic [TW-1:0] tmo;
   logic [7:0]    held;
   logic          is_amp;
   logic          fits1;
   logic          fits2;
   logic          expired;
   logic          wr_en;
   logic [7:0]    wr_idx;
   logic [7:0]    wr_byte;

   assign is_amp  = (uart_rx_data == AMP_CHAR);
   assign fits1   = ({1'b0, cnt} < CAP);
   assign fits2   = (({1'b0, cnt} + 9'd2) <= CAP);
   assign expired = (state != S_IDLE) && !uart_rx_vld && (tmo == TMO_LAST);

   // Buffer write port: a lone payload '&' is written first, its follower one cycle later.
   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = cnt;
      wr_byte = uart_rx_data;
      case (state)
         S_CONTENT: begin
            if (uart_rx_vld && !is_amp && fits1) begin
               wr_en = 1'b1;
            end else begin
               wr_en = 1'b0;
            end
         end
         S_AMP: begin
            if (uart_rx_vld && !is_amp && fits2) begin
               wr_en   = 1'b1;
               wr_byte = AMP_CHAR;
            end else begin
               wr_en = 1'b0;
            end
         end
         S_WR2: begin
            wr_en   = 1'b1;
            wr_idx  = cnt + 8'd1;
            wr_byte = held;
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

   // Payload buffer is written in place and never cleared between frames.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rx_string <= '0;
      end else begin
         for (int k = 0; k < MAX_LEN; k++) begin
            if (wr_en && (wr_idx == 8'(k))) begin
               rx_string[8*k +: 8] <= wr_byte;
            end
         end
      end
   end

   // Frame state machine with inline inter-byte timeout; a strobe always beats expiry.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= S_IDLE;
         cnt         <= 8'd0;
         tmo         <= '0;
         held        <= 8'd0;
         rx_length   <= 8'd0;
         rx_busy     <= 1'b0;
         rx_done     <= 1'b0;
         rx_err      <= 1'b0;
         rx_err_code <= 2'b00;
      end else begin
         rx_done <= 1'b0;
         rx_err  <= 1'b0;
         tmo     <= (state == S_IDLE || uart_rx_vld) ? '0 : tmo + TW'(1);
         if (expired) begin
            state       <= S_IDLE;
            rx_busy     <= 1'b0;
            rx_err      <= 1'b1;
            rx_err_code <= ERR_TMO;
         end else begin
            case (state)
               S_IDLE: begin
                  if (uart_rx_vld && is_amp) begin
                     state   <= S_SYNC1;
                     rx_busy <= 1'b1;
                  end
               end
               S_SYNC1: begin
                  if (uart_rx_vld) begin
                     if (is_amp) begin
                        state <= S_CONTENT;
                        cnt   <= 8'd0;
                     end else begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                     end
                  end
               end
               S_CONTENT: begin
                  if (uart_rx_vld) begin
                     if (is_amp) begin
                        state <= S_AMP;
                     end else if (fits1) begin
                        cnt <= cnt + 8'd1;
                     end else begin
                        state       <= S_IDLE;
                        rx_busy     <= 1'b0;
                        rx_err      <= 1'b1;
                        rx_err_code <= ERR_OVF;
                     end
                  end
               end
               S_AMP: begin
                  if (uart_rx_vld) begin
                     if (is_amp) begin
                        state     <= S_DONE;
                        rx_length <= cnt;
                        rx_done   <= 1'b1;
                     end else if (fits2) begin
                        held  <= uart_rx_data;
                        state <= S_WR2;
                     end else begin
                        state       <= S_IDLE;
                        rx_busy     <= 1'b0;
                        rx_err      <= 1'b1;
                        rx_err_code <= ERR_OVF;
                     end
                  end
               end
               S_WR2: begin
                  cnt   <= cnt + 8'd2;
                  state <= S_CONTENT;
               end
               S_DONE: begin
                  state   <= S_IDLE;
                  rx_busy <= 1'b0;
               end
               default: begin
                  state   <= S_IDLE;
                  rx_busy <= 1'b0;
                  cnt     <= 8'd0;
               end
            endcase
         end
      end
   end

endmodule
